// File: rtl/tdc_multi.sv
// tdc_multi: multi-channel time-to-digital converter.
//
// Each asynchronous detector pulse is synchronised into clk, then edge
// detected into a registered one-cycle hit flag. The time between consecutive
// hit groups (the channels hit in the same cycle) is measured in clock periods
// and emitted as a {start_mask, end_mask, interval} record through a one-deep
// valid/ready output register. Records that find the register full are
// dropped and counted in drop_count, which saturates.
//
// Optional feature: define TDC_TIMEOUT_RECORD_EN to emit a timeout record
// {start_mask, 0, MAX_INTERVAL} when a measurement expires without an end hit.
//
// Ports:
//   clk          sample / measurement clock
//   rst_n        synchronous active-low reset
//   pulse        asynchronous detector pulses, active-high, one bit per channel
//   out_ready    downstream accepts the record while out_valid is high
//   out_valid    record present
//   out_start    channel mask of the start hit group
//   out_end      channel mask of the end hit group (0 only for timeout records)
//   out_interval cycles from start detection to end detection
//   drop_count   records lost to backpressure, saturating at 0xFFFF
//   armed        high while a measurement is running
module tdc_multi #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 8,
  parameter int MAX_INTERVAL = 127,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] pulse,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [CHANNELS-1:0] out_start,
  output logic [CHANNELS-1:0] out_end,
  output logic [CNT_W-1:0]    out_interval,
  output logic [15:0]         drop_count,
  output logic                armed
);

  typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_INTERVAL);

  // True when two or more channels are set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input logic [CHANNELS-1:0] v);
    return (v & (v - CHANNELS'(1))) != '0;
  endfunction

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_r;
  logic [CHANNELS-1:0] prev_r;
  logic [CHANNELS-1:0] hit_r;

  state_t              state_r, state_n;
  logic [CNT_W-1:0]    k_r, k_n;
  logic [CHANNELS-1:0] start_mask_r, start_mask_n;
  logic [CNT_W:0]      k_inc_s;

  logic                rec_valid_s;
  logic [CHANNELS-1:0] rec_start_s;
  logic [CHANNELS-1:0] rec_end_s;
  logic [CNT_W-1:0]    rec_interval_s;

  // Synchroniser chain, previous-sample register and registered rising-edge hit flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= '0;
      hit_r  <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pulse};
      prev_r <= sync_r[SYNC_STAGES-1];
      hit_r  <= sync_r[SYNC_STAGES-1] & ~prev_r;
    end
  end

  // Measurement state register; independent of out_ready by construction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      k_r          <= '0;
      start_mask_r <= '0;
    end else begin
      state_r      <= state_n;
      k_r          <= k_n;
      start_mask_r <= start_mask_n;
    end
  end

  assign k_inc_s = {1'b0, k_r} + (CNT_W + 1)'(1);

  // Next-state logic and record generation.
  always_comb begin
    state_n        = state_r;
    k_n            = k_r;
    start_mask_n   = start_mask_r;
    rec_valid_s    = 1'b0;
    rec_start_s    = '0;
    rec_end_s      = '0;
    rec_interval_s = '0;
    case (state_r)
      IDLE: begin
        if (hit_r != '0) begin
          state_n      = ARMED;
          k_n          = '0;
          start_mask_n = hit_r;
          // Only a coincident group reports itself as an interval-0 record.
          if (multi_hot(hit_r)) begin
            rec_valid_s = 1'b1;
            rec_end_s   = hit_r;
          end else begin
            rec_valid_s = 1'b0;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ARMED: begin
        if ((hit_r != '0) && (k_inc_s <= MAX_C)) begin
          // End hit; the same group immediately starts the next measurement.
          rec_valid_s    = 1'b1;
          rec_start_s    = start_mask_r;
          rec_end_s      = hit_r;
          rec_interval_s = k_inc_s[CNT_W-1:0];
          start_mask_n   = hit_r;
          k_n            = '0;
        end else if ((hit_r == '0) && (k_inc_s == MAX_C)) begin
          state_n      = IDLE;
          start_mask_n = '0;
          k_n          = '0;
`ifdef TDC_TIMEOUT_RECORD_EN
          rec_valid_s    = 1'b1;
          rec_start_s    = start_mask_r;
          rec_end_s      = '0;
          rec_interval_s = CNT_W'(MAX_INTERVAL);
`else
          rec_valid_s    = 1'b0;
`endif
        end else begin
          k_n = k_inc_s[CNT_W-1:0];
        end
      end
      default: begin
        state_n      = IDLE;
        k_n          = '0;
        start_mask_n = '0;
      end
    endcase
  end

  // One-deep output register with saturating drop accounting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_start    <= '0;
      out_end      <= '0;
      out_interval <= '0;
      drop_count   <= 16'd0;
    end else if (rec_valid_s) begin
      if (!out_valid || out_ready) begin
        out_valid    <= 1'b1;
        out_start    <= rec_start_s;
        out_end      <= rec_end_s;
        out_interval <= rec_interval_s;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign armed = (state_r == ARMED);

endmodule

// File: doc/tdc_multi.md
# tdc_multi

Parametrised multi-channel successor to the two-input time-to-digital converter. Each photon-counter input is synchronised into the `clk` domain and reduced to one-cycle hit flags. The time between consecutive hit groups is measured in clock periods and emitted as a `{start_mask, end_mask, interval}` record over a valid/ready interface. It sits between the detector front-end pins and the correlation histogrammer / readout FIFO.

## Interface
- `CHANNELS`, 2 — number of pulse inputs (1..8).
- `CNT_W`, 8 — interval counter and output width.
- `MAX_INTERVAL`, 127 — last interval value (in cycles) still accepted as an end hit; must be < 2^CNT_W.
- `SYNC_STAGES`, 2 — synchroniser flops per channel (≥2).
- `clk` in 1 — sample/measurement clock (500 MHz target, 2 ns per count).
- `rst_n` in 1 — reset, synchronous, active-low.
- `pulse` in CHANNELS — asynchronous detector pulses, active-high.
- `out_ready` in 1 — downstream accepts the record when high with `out_valid`.
- `out_valid` out 1 — record present.
- `out_start` out CHANNELS — channel mask of the start hit group.
- `out_end` out CHANNELS — channel mask of the end hit group (0 only for timeout records).
- `out_interval` out CNT_W — cycles from start detection to end detection.
- `drop_count` out 16 — records lost to backpressure, saturating.
- `armed` out 1 — high while in ARMED.

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then a rising-edge detector (previous-sample register). `hit[i]` is high for exactly one cycle per rising edge. Sync and previous-sample flops reset to 0, so a pulse held high through reset release yields one hit.
- Hit group: `hit` ≠ 0 in a given cycle. Its mask is `hit`. Channels hit in the same cycle are coincident.
- States: IDLE, ARMED. `k` = cycles since the start detection, CNT_W bits.
- IDLE, single-channel group: `start_mask <= hit`, `k <= 0`, go to ARMED. No record is emitted.
- IDLE, group with ≥2 channels: emit record `{start=0, end=hit, interval=0}`, `start_mask <= hit`, go to ARMED.
- ARMED, any group with `k+1 ≤ MAX_INTERVAL`: emit record `{start=start_mask, end=hit, interval=k+1}`, `start_mask <= hit`, `k <= 0`, stay ARMED (chaining).
  - A multi-channel group in ARMED emits only this one record. It does not also emit the interval-0 coincidence record.
- ARMED, no hit, `k+1 == MAX_INTERVAL`: go to IDLE. `start_mask` is cleared. Timeout record only with the macro (see Configuration).
- Otherwise in ARMED: `k <= k+1`.
- Output register (one deep):
  - Loaded with a new record when `!out_valid || out_ready`.
  - Otherwise the new record is dropped and `drop_count` increments, saturating at 0xFFFF.
  - `out_valid` falls after a transfer if no new record arrives in the same cycle.
  - Sustained throughput: one record per cycle.
- Measurement state (IDLE/ARMED, `k`, `start_mask`) never depends on `out_ready`.

## Timing
- Reset (`rst_n` low at a `clk` edge): `out_valid=0`, `out_start=0`, `out_end=0`, `out_interval=0`, `drop_count=0`, `armed=0`, state IDLE, `k=0`, all sync flops 0. Asserting reset mid-measurement aborts it with no record.
- Latency: a pulse first sampled high at edge E produces a hit at edge E+SYNC_STAGES. The record is visible (`out_valid=1`) after edge E+SYNC_STAGES+1.
- Interval resolution is one cycle. Both edges pass through identical pipelines, so the latency cancels.
- Intervals below 1 cycle between different channels read as coincidence (0). A same-channel re-hit needs ≥2 cycles (pulse must go low for one sample).
- `armed` goes high the cycle after the start hit and low the cycle after timeout.
- Last accepted end hit is at interval MAX_INTERVAL. A hit at MAX_INTERVAL+1 finds IDLE and starts a new measurement.

## Configuration
- `TDC_TIMEOUT_RECORD_EN` defined: on timeout, emit record `{start=start_mask, end=0, interval=MAX_INTERVAL}` through the same output path, including drop accounting.
- Not defined: timeout returns to IDLE silently. `out_end` is never 0 while `out_valid`, except for the interval-0 coincidence record's `out_start`.

## Test plan
- Defaults, `out_ready=1`; ch0 edge, then ch1 edge 10 cycles later → one record `{start=01, end=10, interval=10}`; `armed` stays high.
- Channels 0 and 1 rise in the same cycle from IDLE; ch0 again 5 cycles later → records `{00,11,0}` then `{11,01,5}`.
- ch0 edge then no hits: `armed` falls at interval 127 with no record. Repeat with `TDC_TIMEOUT_RECORD_EN` → `{01,00,127}`. End hit at exactly 127 → `{01,xx,127}`; end hit at 128 → no record, new start.
- `out_ready=0`; three single-channel hits 3 cycles apart after a start → first record held unchanged, `drop_count=2`. Raise `out_ready` → record transfers, `out_valid` falls.
- `CHANNELS=4`, `CNT_W=10`, `MAX_INTERVAL=1000`: ch2 then ch3 at 900 cycles → `{0100,1000,900}`. Assert `rst_n=0` mid-measurement → all outputs 0 next cycle, no record.
